// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch PC generator:
// FSM state and next-PC source encoding.
package pc_gen_pkg;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SRC_SEQ   = 3'd0,
    SRC_TRAP  = 3'd1,
    SRC_REDIR = 3'd2,
    SRC_CALL  = 3'd3,
    SRC_RET   = 3'd4,
    SRC_HOLD  = 3'd5
  } src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full
// overwrites the oldest entry.
module pc_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               top_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // ptr_q is the next write slot; the top sits just below it
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != FULL)
        cnt_d = cnt_q + CW'(1);
    end else if (pop_i && cnt_q != '0) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i)
      mem_q[ptr_q] <= data_i;
  end

  assign top_o   = mem_q[ptr_q - PW'(1)];
  assign count_o = cnt_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: boot FSM, next-PC priority mux
// and return-address stack for call/return prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_VEC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC    = 32'h0000_0100,
  parameter int              RAS_DEPTH   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         stall_i,
  input  logic                         redirect_i,
  input  logic [XLEN-1:0]              redirect_pc_i,
  input  logic                         trap_i,
  input  logic                         call_i,
  input  logic [XLEN-1:0]              call_target_i,
  input  logic                         ret_i,
  output logic [XLEN-1:0]              pc_o,
  output logic                         pc_valid_o,
  output logic                         ret_miss_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam logic [XLEN-1:0] MASK =
    ~(XLEN'(INSTR_BYTES - 1));

  state_e          state_q, state_d;
  src_e            src;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            miss_q, miss_d;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] ras_top;
  logic [CW-1:0]   ras_count;
  logic            ras_push, ras_pop, ras_flush;

  assign seq_pc = pc_q + XLEN'(INSTR_BYTES);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    miss_d  = 1'b0;
    src     = SRC_HOLD;
    if (state_q == BOOT) begin
      state_d = RUN;
      valid_d = 1'b1;
    end else if (trap_i) begin
      src = SRC_TRAP;
    end else if (redirect_i) begin
      src = SRC_REDIR;
    end else if (stall_i) begin
      src = SRC_HOLD;
    end else if (call_i) begin
      src = SRC_CALL;
    end else if (ret_i) begin
      if (ras_count != '0) begin
        src = SRC_RET;
      end else begin
        src    = SRC_SEQ;
        miss_d = 1'b1;
      end
    end else begin
      src = SRC_SEQ;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (src)
      SRC_SEQ:   pc_d = seq_pc;
      SRC_TRAP:  pc_d = TRAP_VEC & MASK;
      SRC_REDIR: pc_d = redirect_pc_i & MASK;
      SRC_CALL:  pc_d = call_target_i & MASK;
      SRC_RET:   pc_d = ras_top & MASK;
      default:   pc_d = pc_q;
    endcase
  end

  assign ras_push  = (src == SRC_CALL);
  assign ras_pop   = (src == SRC_RET);
  assign ras_flush = (src == SRC_TRAP);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      miss_q  <= miss_d;
    end
  end

  pc_ras #(
    .W     (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .flush_i (ras_flush),
    .data_i  (seq_pc),
    .top_o   (ras_top),
    .count_o (ras_count)
  );

  assign pc_o        = pc_q;
  assign pc_valid_o  = valid_q;
  assign ret_miss_o  = miss_q;
  assign ras_count_o = ras_count;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios with literal
// expectations plus randomized traffic against a queue model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        stall_i, redirect_i, trap_i, call_i, ret_i;
  logic [31:0] redirect_pc_i, call_target_i;
  logic [31:0] pc_o;
  logic        pc_valid_o, ret_miss_o;
  logic [2:0]  ras_count_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic        m_valid, m_run, m_miss;
  logic [31:0] m_ras[$];

  pc_gen dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .trap_i        (trap_i),
    .call_i        (call_i),
    .call_target_i (call_target_i),
    .ret_i         (ret_i),
    .pc_o          (pc_o),
    .pc_valid_o    (pc_valid_o),
    .ret_miss_o    (ret_miss_o),
    .ras_count_o   (ras_count_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_run   = 1'b0;
    m_miss  = 1'b0;
    m_ras.delete();
  endfunction

  function automatic void model_edge();
    if (rst_i) begin
      model_reset();
    end else if (!m_run) begin
      m_run   = 1'b1;
      m_valid = 1'b1;
      m_miss  = 1'b0;
    end else begin
      m_miss = 1'b0;
      if (trap_i) begin
        m_pc = 32'h100;
        m_ras.delete();
      end else if (redirect_i) begin
        m_pc = {redirect_pc_i[31:2], 2'b00};
      end else if (stall_i) begin
        m_pc = m_pc;
      end else if (call_i) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
        m_pc = {call_target_i[31:2], 2'b00};
      end else if (ret_i) begin
        if (m_ras.size() > 0) begin
          m_pc = m_ras.pop_back();
        end else begin
          m_pc   = m_pc + 32'd4;
          m_miss = 1'b1;
        end
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  function automatic void compare();
    chk("pc", pc_o, m_pc);
    chk("valid", {31'b0, pc_valid_o}, {31'b0, m_valid});
    chk("ret_miss", {31'b0, ret_miss_o}, {31'b0, m_miss});
    chk("count", {29'b0, ras_count_o}, 32'(m_ras.size()));
  endfunction

  task automatic idle();
    stall_i = 0; redirect_i = 0; trap_i = 0;
    call_i = 0; ret_i = 0;
    redirect_pc_i = 0; call_target_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    idle();
  endtask

  task automatic go(logic [31:0] a);
    redirect_i = 1; redirect_pc_i = a;
    step();
  endtask

  task automatic call(logic [31:0] t);
    call_i = 1; call_target_i = t;
    step();
  endtask

  task automatic async_reset();
    #2 rst_i = 1;
    #1;
    model_reset();
    chk("async_pc", pc_o, 32'h0);
    chk("async_valid", {31'b0, pc_valid_o}, 32'h0);
    compare();
    @(negedge clk);
    step();
    rst_i = 0;
  endtask

  initial begin
    rst_i = 1;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", {31'b0, pc_valid_o}, 32'h0);
    rst_i = 0;
    compare();
    step();
    chk("boot_pc", pc_o, 32'h0);
    chk("boot_valid", {31'b0, pc_valid_o}, 32'h1);
    step();
    chk("seq1", pc_o, 32'h4);
    step();
    chk("seq2", pc_o, 32'h8);

    go(32'h20);
    repeat (3) begin
      stall_i = 1;
      step();
      chk("stall_hold", pc_o, 32'h20);
    end
    stall_i = 1;
    go(32'h203);
    chk("stall_redir", pc_o, 32'h200);

    go(32'h40);
    call(32'h80);
    chk("call_pc", pc_o, 32'h80);
    chk("call_cnt", {29'b0, ras_count_o}, 32'd1);
    step();
    ret_i = 1;
    step();
    chk("ret_pc", pc_o, 32'h44);
    chk("ret_cnt", {29'b0, ras_count_o}, 32'd0);

    for (int i = 1; i <= 5; i++) begin
      go(32'(i * 16));
      call(32'h1000);
    end
    chk("ovf_cnt", {29'b0, ras_count_o}, 32'd4);
    for (int i = 5; i >= 2; i--) begin
      ret_i = 1;
      step();
      chk("ovf_ret", pc_o, 32'(i * 16 + 4));
    end
    ret_i = 1;
    step();
    chk("udf_pc", pc_o, 32'h28);
    chk("udf_miss", {31'b0, ret_miss_o}, 32'h1);
    step();
    chk("udf_pulse", {31'b0, ret_miss_o}, 32'h0);

    call(32'h60);
    call(32'h70);
    chk("pre_trap_cnt", {29'b0, ras_count_o}, 32'd2);
    trap_i = 1; redirect_i = 1; redirect_pc_i = 32'h500;
    call_i = 1; call_target_i = 32'h600;
    step();
    chk("trap_pc", pc_o, 32'h100);
    chk("trap_cnt", {29'b0, ras_count_o}, 32'd0);

    go(32'h300);
    call_i = 1; ret_i = 1; call_target_i = 32'h400;
    step();
    chk("callret_pc", pc_o, 32'h400);
    chk("callret_cnt", {29'b0, ras_count_o}, 32'd1);

    go(32'hFFFF_FFFC);
    step();
    chk("wrap", pc_o, 32'h0);

    async_reset();
    step();
    step();
    chk("post_rst", pc_o, 32'h4);

    for (int n = 0; n < 3000; n++) begin
      trap_i        = ($urandom_range(0, 31) == 0);
      redirect_i    = ($urandom_range(0, 7) == 0);
      stall_i       = ($urandom_range(0, 4) == 0);
      call_i        = ($urandom_range(0, 3) == 0);
      ret_i         = ($urandom_range(0, 2) == 0);
      redirect_pc_i = $urandom;
      call_target_i = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        idle();
        async_reset();
      end else begin
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch program-counter generator; the next generation of the core's PC register. Holds the fetch PC and selects the next PC from: sequential increment, EX-stage redirect (branch/jump resolution), trap vector, and a small return-address stack (RAS) for call/return prediction. Supports the hazard-unit stall hold. It sits at the head of the IF stage, feeding instruction memory and the IF/ID register.

## Interface
Parameters:
- XLEN, 32, PC and address width.
- INSTR_BYTES, 4, sequential increment (power of two, ≥2).
- RESET_VEC, 32'h0000_0000, PC after reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on trap.
- RAS_DEPTH, 4, return-stack entries (power of two, ≥2).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- stall_i  in  1  hazard hold; PC and RAS frozen.
- redirect_i  in  1  EX-resolved control transfer.
- redirect_pc_i  in  XLEN  redirect target.
- trap_i  in  1  exception/trap entry.
- call_i  in  1  fetched instruction is a call.
- call_target_i  in  XLEN  call target.
- ret_i  in  1  fetched instruction is a return.
- pc_o  out  XLEN  current fetch PC.
- pc_valid_o  out  1  pc_o is a valid fetch address.
- ret_miss_o  out  1  one-cycle pulse: return seen with empty RAS.
- ras_count_o  out  $clog2(RAS_DEPTH)+1  valid RAS entries.

## Operation
- FSM states: BOOT, RUN. Reset → BOOT. BOOT → RUN on the first clock edge after rst_i deasserts; all request inputs are ignored in BOOT.
- In RUN, the next PC uses this priority, highest first:
  - trap_i: pc ← TRAP_VEC; RAS flushed (count ← 0).
  - redirect_i: pc ← redirect_pc_i; RAS unchanged. Wins over stall_i.
  - stall_i: pc held; call_i and ret_i ignored; RAS unchanged.
  - call_i: pc ← call_target_i; push pc_o+INSTR_BYTES. If call_i and ret_i are both asserted, call wins and ret is ignored.
  - ret_i with count>0: pc ← top entry; pop.
  - ret_i with count=0: pc ← pc_o+INSTR_BYTES; ret_miss_o=1 next cycle.
  - otherwise: pc ← pc_o+INSTR_BYTES.
- Alignment: low log2(INSTR_BYTES) bits of every loaded target are forced to 0.
- Arithmetic: the increment is modulo 2^XLEN, so 32'hFFFF_FFFC+4 wraps to 0.
- RAS is circular. A push when full overwrites the oldest entry and count stays at RAS_DEPTH. A pop decrements count; the pointer wraps modulo RAS_DEPTH.

## Timing
- Reset values:
  - pc_o=RESET_VEC, pc_valid_o=0, ret_miss_o=0, ras_count_o=0, state=BOOT.
  - RAS entry contents are don't-care.
- pc_valid_o is 0 in BOOT and goes to 1 in the cycle after the BOOT→RUN edge. pc_o stays RESET_VEC through that transition.
- Every PC update takes effect one clock after its request is sampled; all outputs are registered.
- ret_miss_o is high for exactly one cycle.
- Asserting rst_i mid-operation immediately forces the reset values, asynchronously, and discards any pending push/pop.
- A stall lasting N cycles holds pc_o constant for N cycles. The first unstalled edge applies the request present on that edge.

## Structure
- Package pc_gen_pkg: state enum (BOOT, RUN); next-PC source encoding (SRC_SEQ, SRC_TRAP, SRC_REDIR, SRC_CALL, SRC_RET, SRC_HOLD).
- The priority mux and FSM live in pc_gen.
- Sub-module pc_ras: parametrised circular stack.
  - Inputs: push, pop, flush, push data.
  - Outputs: top, count.
  - Instantiated once.

## Test plan
- Reset/boot, with defaults:
  - With rst_i high: pc_o=0, pc_valid_o=0.
  - Release rst_i, 3 idle edges → pc_o sequence 0, 0, 4, 8, with pc_valid_o rising on the second sample.
- Stall vs redirect:
  - stall_i for 3 cycles at pc=0x20 → pc_o holds 0x20.
  - stall_i together with redirect_i, redirect_pc_i=0x203 → pc_o=0x200 next cycle.
- Call/return:
  - At pc=0x40, call_i with target 0x80 → pc=0x80, count=1.
  - At pc=0x84, ret_i → pc=0x44, count=0.
- RAS overflow/underflow:
  - 5 calls from 0x10, 0x20, 0x30, 0x40, 0x50 → count saturates at 4.
  - 4 returns yield 0x54, 0x44, 0x34, 0x24.
  - A 5th return → pc+4 and a single-cycle ret_miss_o.
- Trap and priority:
  - trap_i with redirect_i and call_i at count=2 → pc=0x100, count=0.
  - call_i with ret_i → call wins.
- Wrap and async reset:
  - At pc=0xFFFF_FFFC, an idle edge → pc=0.
  - Assert rst_i between edges → pc_o=RESET_VEC and pc_valid_o=0 before the next clock edge.
